pe_acc_unit: RTL and testbench

- Accumulation back-end of a PE. Consumes the FU result stream (res/valid) and sums a programmed number of samples. Presents the sum downstream with a valid/ready handshake.
- Drives the FU's accumulator-ready input; this is the producing end of the ACC handshake the FU waits on.
- Sits between the FU output and the PE output register / NoC port.

---
 rtl/pe_acc_unit.sv | 101 ++++++++++
 tb/tb_pe_acc_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_unit.sv
// Accumulation back-end of a PE: sums a programmed number of FU result
// samples and presents the sum downstream over a valid/ready handshake.
module pe_acc_unit #(
    parameter int N_BITS = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              sat_en_i,
    input  logic [LEN_W-1:0]  acc_len_i,
    input  logic [N_BITS-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [N_BITS-1:0] res_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              acc_ready_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N_BITS-1:0] MAX_POS = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic [N_BITS-1:0] MAX_NEG = {1'b1, {(N_BITS-1){1'b0}}};

    state_t             state;
    logic [N_BITS-1:0]  acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic               ovf;

    logic               accept;
    logic [LEN_W-1:0]   len_new;
    logic [N_BITS:0]    sum;
    logic               sum_ovf;
    logic [N_BITS-1:0]  sum_res;
    logic               last;

    assign ready_o     = en_i & ((state != DONE) | ready_i);
    assign accept      = valid_i & ready_o;
    assign len_new     = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;

    // One extra bit of headroom; overflow shows as a top-two-bit mismatch.
    assign sum         = {acc[N_BITS-1], acc} + {data_i[N_BITS-1], data_i};
    assign sum_ovf     = sum[N_BITS] ^ sum[N_BITS-1];
    assign last        = (cnt + LEN_W'(1)) == len_q;

    always_comb begin
        sum_res = sum[N_BITS-1:0];
        if (sum_ovf && sat_en_i) begin
            sum_res = sum[N_BITS] ? MAX_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        len_q <= len_new;
                        acc   <= data_i;
                        cnt   <= LEN_W'(1);
                        ovf   <= 1'b0;
                        state <= (len_new == LEN_W'(1)) ? DONE : ACCUM;
                    end else if (state == DONE && ready_i) begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= sum_res;
                        cnt   <= cnt + LEN_W'(1);
                        ovf   <= ovf | sum_ovf;
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid_o     = (state == DONE);
    assign acc_ready_o = valid_o;
    assign res_o       = acc;
    assign overflow_o  = ovf;

endmodule

// File: tb/tb_pe_acc_unit.sv
// Scoreboard bench for pe_acc_unit: expected sums are queued as samples are
// driven and checked on every downstream handshake.
module tb_pe_acc_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        clear_i;
    logic        sat_en_i;
    logic [7:0]  acc_len_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] res_o;
    logic        valid_o;
    logic        ready_i;
    logic        acc_ready_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pe_acc_unit dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .clear_i     (clear_i),
        .sat_en_i    (sat_en_i),
        .acc_len_i   (acc_len_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .res_o       (res_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .acc_ready_o (acc_ready_o),
        .overflow_o  (overflow_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every presented sum that is consumed downstream.
    always @(negedge clk) begin
        if (!rst_i && !clear_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(res_o), 64'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res", 64'(res_o), 64'(e.res));
                check("ovf", 64'(overflow_o), 64'(e.ovf));
                check("acc_ready", 64'(acc_ready_o), 64'd1);
            end
        end
    end

    task automatic expect_sum(input logic [31:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        sb.push_back(e);
    endtask

    // Holds the sample until it is accepted; valid_i stays high afterwards
    // so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] d);
        logic ok;
        int   n;
        valid_i = 1'b1;
        data_i  = d;
        n = 0;
        do begin
            @(negedge clk);
            ok = ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        en_i      = 1'b1;
        clear_i   = 1'b0;
        sat_en_i  = 1'b0;
        acc_len_i = 8'd4;
        data_i    = '0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_accr", 64'(acc_ready_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("idle_ready", 64'(ready_o), 64'd1);

        // len 4: 1+2+3+4
        expect_sum(32'd10, 1'b0);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd4);
        idle(2);
        check("len4_drop", 64'(valid_o), 64'd0);

        // len 0 acts as 1, back-to-back results
        acc_len_i = 8'd0;
        expect_sum(32'd5, 1'b0);
        expect_sum(-32'sd7, 1'b0);
        send(32'd5);
        send(-32'sd7);
        idle(2);

        // saturate then wrap
        acc_len_i = 8'd2;
        sat_en_i  = 1'b1;
        expect_sum(32'h7FFF_FFFF, 1'b1);
        send(32'h7FFF_FFF0);
        send(32'h0000_0020);
        idle(2);
        sat_en_i = 1'b0;
        expect_sum(32'h8000_0010, 1'b1);
        send(32'h7FFF_FFF0);
        send(32'h0000_0020);
        idle(2);

        // backpressure hold
        expect_sum(32'd7, 1'b0);
        send(32'd3);
        send(32'd4);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd0);
            check("hold_res", 64'(res_o), 64'd7);
            check("hold_valid", 64'(valid_o), 64'd1);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        send(32'd9);
        expect_sum(32'd10, 1'b0);
        send(32'd1);
        idle(2);

        // clear mid-sum
        acc_len_i = 8'd3;
        send(32'd100);
        send(32'd200);
        idle(1);
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        check("clr_valid", 64'(valid_o), 64'd0);
        expect_sum(32'd3, 1'b0);
        send(32'd1);
        send(32'd1);
        send(32'd1);
        idle(2);

        // len change ignored, en stall, reset in DONE
        acc_len_i = 8'd3;
        send(32'd1);
        acc_len_i = 8'd1;
        en_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_ready", 64'(ready_o), 64'd0);
            check("stall_res", 64'(res_o), 64'd1);
            @(posedge clk);
            #1;
        end
        en_i = 1'b1;
        send(32'd2);
        check("mid_valid", 64'(valid_o), 64'd0);
        ready_i = 1'b0;
        send(32'd3);
        valid_i = 1'b0;
        @(negedge clk);
        check("done_valid", 64'(valid_o), 64'd1);
        check("done_res", 64'(res_o), 64'd6);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_valid", 64'(valid_o), 64'd0);
        check("rst2_res", 64'(res_o), 64'd0);
        check("rst2_accr", 64'(acc_ready_o), 64'd0);
        check("rst2_ovf", 64'(overflow_o), 64'd0);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        idle(2);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
